score_keeper: RTL and testbench

Match-state controller that sits upstream of the score renderer. It counts points from the ball-miss events, holds the game frozen for a fixed number of frames after each point, and issues a single serve pulse to restart the ball. It detects the winning score and holds a game-over state until restart. Its score outputs feed the renderer stage directly, which displays the digits 0–9.

---
 rtl/score_keeper.sv | 103 ++++++++++
 tb/tb_score_keeper.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: match-state controller that counts points, freezes play between
// points, launches serves, and holds game-over until a restart request.
module score_keeper #(
    parameter int M_SCORE_W    = 4,
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 frame_tick_i,
    input  logic                 miss_player_i,
    input  logic                 miss_enemy_i,
    input  logic                 restart_i,
    output logic [M_SCORE_W-1:0] player_score_o,
    output logic [M_SCORE_W-1:0] enemy_score_o,
    output logic                 freeze_o,
    output logic                 serve_o,
    output logic                 serve_dir_o,
    output logic                 game_over_o,
    output logic                 winner_o
);
    localparam int CW = $clog2(PAUSE_FRAMES + 1);
    localparam logic [CW-1:0]        LAST = CW'(PAUSE_FRAMES - 1);
    localparam logic [M_SCORE_W-1:0] WIN  = M_SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {PAUSE, SERVE, PLAY, OVER} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [M_SCORE_W-1:0]  player_q, player_d, enemy_q, enemy_d;
    logic                  dir_q, dir_d, winner_q, winner_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        player_d = player_q;
        enemy_d  = enemy_q;
        dir_d    = dir_q;
        winner_d = winner_q;
        if (restart_i) begin
            state_d  = PAUSE;
            cnt_d    = '0;
            player_d = '0;
            enemy_d  = '0;
            dir_d    = 1'b0;
            winner_d = 1'b0;
        end else begin
            case (state_q)
                PAUSE: begin
                    if (frame_tick_i) begin
                        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                        state_d = (cnt_q == LAST) ? SERVE : PAUSE;
                    end
                end
                SERVE: state_d = PLAY;
                PLAY: begin
                    // A simultaneous double miss is credited to the enemy only.
                    if (miss_player_i) begin
                        enemy_d  = enemy_q + M_SCORE_W'(1);
                        dir_d    = 1'b1;
                        winner_d = (enemy_d == WIN) ? 1'b1 : winner_q;
                        state_d  = (enemy_d == WIN) ? OVER : PAUSE;
                        cnt_d    = '0;
                    end else if (miss_enemy_i) begin
                        player_d = player_q + M_SCORE_W'(1);
                        dir_d    = 1'b0;
                        winner_d = (player_d == WIN) ? 1'b0 : winner_q;
                        state_d  = (player_d == WIN) ? OVER : PAUSE;
                        cnt_d    = '0;
                    end
                end
                OVER:    state_d = OVER;
                default: state_d = PAUSE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PAUSE;
            cnt_q    <= '0;
            player_q <= '0;
            enemy_q  <= '0;
            dir_q    <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            player_q <= player_d;
            enemy_q  <= enemy_d;
            dir_q    <= dir_d;
            winner_q <= winner_d;
        end
    end

    assign player_score_o = player_q;
    assign enemy_score_o  = enemy_q;
    assign freeze_o       = (state_q != PLAY);
    assign serve_o        = (state_q == SERVE);
    assign game_over_o    = (state_q == OVER);
    assign serve_dir_o    = dir_q;
    assign winner_o       = winner_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed stimulus against an event-level match
// model; expected observations are queued and compared by an independent monitor.
module tb_score_keeper;
    localparam int PF = 3;
    localparam int WS = 3;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic frame_tick_i = 1'b0, miss_player_i = 1'b0, miss_enemy_i = 1'b0, restart_i = 1'b0;
    logic [W-1:0] player_score_o, enemy_score_o;
    logic freeze_o, serve_o, serve_dir_o, game_over_o, winner_o;

    score_keeper #(.M_SCORE_W(W), .WIN_SCORE(WS), .PAUSE_FRAMES(PF)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .frame_tick_i(frame_tick_i),
        .miss_player_i(miss_player_i), .miss_enemy_i(miss_enemy_i), .restart_i(restart_i),
        .player_score_o(player_score_o), .enemy_score_o(enemy_score_o),
        .freeze_o(freeze_o), .serve_o(serve_o), .serve_dir_o(serve_dir_o),
        .game_over_o(game_over_o), .winner_o(winner_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] e;
        logic fr, sv, dir, ov, win;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Match model: points, frames still owed before the next serve, and phase flags.
    int m_p, m_e, m_left;
    bit m_play, m_serve, m_over, m_dir, m_win;

    function automatic obs_t model_obs();
        obs_t o;
        o.p = W'(m_p); o.e = W'(m_e);
        o.fr = !m_play; o.sv = m_serve; o.dir = m_dir; o.ov = m_over; o.win = m_win;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.p = player_score_o; o.e = enemy_score_o;
        o.fr = freeze_o; o.sv = serve_o; o.dir = serve_dir_o; o.ov = game_over_o; o.win = winner_o;
        return o;
    endfunction

    function automatic void model_reset();
        m_p = 0; m_e = 0; m_left = PF;
        m_play = 0; m_serve = 0; m_over = 0; m_dir = 0; m_win = 0;
    endfunction

    function automatic void model_step(bit t, bit mp, bit me, bit rs);
        if (rs) model_reset();
        else if (m_over) begin end
        else if (m_serve) begin m_serve = 0; m_play = 1; end
        else if (m_play) begin
            if (mp || me) begin
                if (mp) begin m_e++; m_dir = 1; end
                else begin m_p++; m_dir = 0; end
                m_play = 0;
                m_left = PF;
                if (m_e == WS || m_p == WS) begin m_over = 1; m_win = (m_e == WS); end
            end
        end else if (t) begin
            m_left--;
            if (m_left == 0) m_serve = 1;
        end
    endfunction

    function automatic void report(string name, obs_t a, obs_t e);
        $display("FAIL %s got p=%0d e=%0d fr=%b sv=%b dir=%b ov=%b win=%b want p=%0d e=%0d fr=%b sv=%b dir=%b ov=%b win=%b",
                 name, a.p, a.e, a.fr, a.sv, a.dir, a.ov, a.win, e.p, e.e, e.fr, e.sv, e.dir, e.ov, e.win);
    endfunction

    task automatic step(bit t, bit mp, bit me, bit rs);
        @(negedge clk);
        frame_tick_i = t; miss_player_i = mp; miss_enemy_i = me; restart_i = rs;
        model_step(t, mp, me, rs);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic ticks(int n);
        repeat (n) step(1, 0, 0, 0);
    endtask

    task automatic wait_play();
        int n = 0;
        while (!m_play && !m_over && n < 50) begin step(1, 0, 0, 0); n++; end
    endtask

    task automatic async_reset();
        obs_t a;
        @(negedge clk);
        frame_tick_i = 0; miss_player_i = 0; miss_enemy_i = 0; restart_i = 0;
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        a = dut_obs();
        checks++;
        if (a !== model_obs()) begin errors++; report("async_reset", a, model_obs()); end
        exp_q.push_back(model_obs());
        repeat (2) begin @(negedge clk); exp_q.push_back(model_obs()); end
        @(negedge clk);
        rst_ni = 1'b1;
        model_step(0, 0, 0, 0);
        exp_q.push_back(model_obs());
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_obs();
                checks++;
                if (a !== e) begin errors++; report("cycle", a, e); end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        obs_t a;
        model_reset();
        #3;
        a = dut_obs();
        checks++;
        if (a !== model_obs()) begin errors++; report("reset", a, model_obs()); end
        @(negedge clk);
        rst_ni = 1'b1;
        model_step(0, 0, 0, 0);
        exp_q.push_back(model_obs());
        // first serve after a full pause
        ticks(3); idle(2);
        // player scores; a frozen miss must not count
        step(0, 0, 1, 0); step(0, 1, 0, 0); ticks(3); idle(2);
        // double miss credits only the enemy
        step(0, 1, 1, 0); ticks(3); idle(2);
        // enemy runs to the winning score, then frozen activity, then restart
        wait_play(); step(0, 1, 0, 0);
        wait_play(); step(0, 1, 0, 0);
        repeat (10) step(1, 1'($urandom), 1'($urandom), 0);
        step(0, 0, 0, 1); ticks(3); idle(2);
        // asynchronous reset mid-pause with the counter at 2
        step(0, 0, 1, 0); ticks(2); async_reset(); ticks(2); idle(1); ticks(1); idle(2);
        // tick on the scoring edge is not counted
        wait_play(); step(1, 0, 1, 0); ticks(2); idle(1); ticks(1); idle(2);
        repeat (3000) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            else step(1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 63) == 0);
        end
        idle(1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
